// File: rtl/param_single_port_ram_pkg.sv
// Shared constants and FSM state type
// for the parameterised single-port RAM.
package param_single_port_ram_pkg;

  localparam int MODE_READ_FIRST  = 0;
  localparam int MODE_WRITE_FIRST = 1;
  localparam int MODE_NO_CHANGE   = 2;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_t;

endpackage

// File: rtl/param_single_port_ram_if.sv
// Request/response bus of the single-port RAM.
// Master issues requests, slave is the RAM.
interface param_single_port_ram_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
);
  logic                    req_valid;
  logic                    req_ready;
  logic                    write_enable;
  logic [ADDR_WIDTH-1:0]   address;
  logic [DATA_WIDTH-1:0]   write_data;
  logic [DATA_WIDTH/8-1:0] byte_enable;
  logic [DATA_WIDTH-1:0]   read_data;
  logic                    read_valid;
  logic                    init_done;

  modport master (
    output req_valid, write_enable, address,
    output write_data, byte_enable,
    input  req_ready, read_data, read_valid,
    input  init_done
  );

  modport slave (
    input  req_valid, write_enable, address,
    input  write_data, byte_enable,
    output req_ready, read_data, read_valid,
    output init_done
  );
endinterface

// File: rtl/sp_ram_array.sv
// Storage array: per-lane write enables and a
// synchronous read-before-write output register.
module sp_ram_array #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                    clk,
  input  logic [DATA_WIDTH/8-1:0] lane_we,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic                    rd_en,
  output logic [DATA_WIDTH-1:0]   rd_q
);
  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (lane_we[i])
        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rd_en)
      rd_q <= mem[addr];
  end
endmodule

// File: rtl/param_single_port_ram.sv
// Single-port RAM with init sweep, byte lanes
// and selectable write-cycle read behaviour.
module param_single_port_ram
  import param_single_port_ram_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6,
  parameter int WRITE_MODE = MODE_NO_CHANGE,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic clock,
  input  logic reset,
  param_single_port_ram_if.slave bus
);
  localparam int NB = DATA_WIDTH / 8;

  state_t state, state_n;
  logic [ADDR_WIDTH-1:0] cnt, cnt_n;

  logic                  accept;
  logic                  rd_en;
  logic [NB-1:0]         lane_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] rd_q;

  logic                  valid_q;
  logic                  have_q;
  logic                  merge_q;
  logic [DATA_WIDTH-1:0] wd_q;
  logic [NB-1:0]         be_q;
  logic [DATA_WIDTH-1:0] rdata;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    accept    = 1'b0;
    rd_en     = 1'b0;
    lane_we   = '0;
    ram_addr  = bus.address;
    ram_wdata = bus.write_data;
    unique case (state)
      INIT: begin
        lane_we   = '1;
        ram_addr  = cnt;
        ram_wdata = INIT_VALUE;
        cnt_n     = cnt + 1'b1;
        if (cnt == '1)
          state_n = READY;
      end
      READY: begin
        accept = bus.req_valid;
        if (accept && bus.write_enable)
          lane_we = bus.byte_enable;
        rd_en = accept && (!bus.write_enable ||
                WRITE_MODE != MODE_NO_CHANGE);
      end
      default: state_n = INIT;
    endcase
  end

  sp_ram_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_array (
    .clk     (clock),
    .lane_we (lane_we),
    .addr    (ram_addr),
    .wdata   (ram_wdata),
    .rd_en   (rd_en),
    .rd_q    (rd_q)
  );

  // Array always reads the old word; write-first
  // lanes are patched in from the captured write.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      have_q  <= 1'b0;
      merge_q <= 1'b0;
      wd_q    <= '0;
      be_q    <= '0;
    end else begin
      valid_q <= rd_en;
      if (rd_en) begin
        have_q  <= 1'b1;
        merge_q <= bus.write_enable &&
                   WRITE_MODE == MODE_WRITE_FIRST;
        wd_q    <= bus.write_data;
        be_q    <= bus.byte_enable;
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (have_q) begin
      for (int i = 0; i < NB; i++)
        rdata[8*i +: 8] = (merge_q && be_q[i]) ?
                          wd_q[8*i +: 8] :
                          rd_q[8*i +: 8];
    end
  end

  assign bus.req_ready  = (state == READY);
  assign bus.init_done  = (state == READY);
  assign bus.read_valid = valid_q;
  assign bus.read_data  = rdata;
endmodule

// File: tb/tb_param_single_port_ram.sv
// Directed bench: three RAMs, one per write mode,
// driven in lockstep with hand-computed results.
module tb_param_single_port_ram;
  import param_single_port_ram_pkg::*;

  localparam int DW = 16;
  localparam int AW = 6;
  localparam logic [DW-1:0] IV = 16'hA5A5;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  param_single_port_ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) rf ();
  param_single_port_ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) wf ();
  param_single_port_ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) nc ();

  param_single_port_ram #(
    .DATA_WIDTH (DW), .ADDR_WIDTH (AW),
    .WRITE_MODE (MODE_READ_FIRST), .INIT_VALUE (IV)
  ) u_rf (.clock(clock), .reset(reset), .bus(rf));

  param_single_port_ram #(
    .DATA_WIDTH (DW), .ADDR_WIDTH (AW),
    .WRITE_MODE (MODE_WRITE_FIRST), .INIT_VALUE (IV)
  ) u_wf (.clock(clock), .reset(reset), .bus(wf));

  param_single_port_ram #(
    .DATA_WIDTH (DW), .ADDR_WIDTH (AW),
    .WRITE_MODE (MODE_NO_CHANGE), .INIT_VALUE (IV)
  ) u_nc (.clock(clock), .reset(reset), .bus(nc));

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic req(input logic we, input int a,
                     input logic [DW-1:0] d,
                     input logic [1:0] be);
    rf.req_valid = 1'b1; wf.req_valid = 1'b1;
    nc.req_valid = 1'b1;
    rf.write_enable = we; wf.write_enable = we;
    nc.write_enable = we;
    rf.address = AW'(a); wf.address = AW'(a);
    nc.address = AW'(a);
    rf.write_data = d; wf.write_data = d;
    nc.write_data = d;
    rf.byte_enable = be; wf.byte_enable = be;
    nc.byte_enable = be;
  endtask

  task automatic idle();
    rf.req_valid = 1'b0; wf.req_valid = 1'b0;
    nc.req_valid = 1'b0;
  endtask

  // one accepted request, sampled after its edge
  task automatic rd(input int a);
    req(1'b0, a, '0, 2'b00);
    step();
    idle();
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d,
                    input logic [1:0] be);
    req(1'b1, a, d, be);
    step();
    idle();
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!nc.req_ready && n < 200) begin
      step();
      n++;
    end
    chk(tag, n, 64);
  endtask

  initial begin
    idle();
    req(1'b0, 0, '0, 2'b00);
    idle();

    step();
    step();
    chk("rst_ready", nc.req_ready, 0);
    chk("rst_valid", nc.read_valid, 0);
    chk("rst_data", nc.read_data, 0);
    chk("rst_done", nc.init_done, 0);

    reset = 1'b0;
    wait_ready("init_cycles");
    chk("init_done", nc.init_done, 1);
    chk("init_wf_ready", wf.req_ready, 1);

    rd(37);
    chk("rd37_valid", nc.read_valid, 1);
    chk("rd37_data", nc.read_data, 16'hA5A5);
    step();
    chk("rd37_pulse", nc.read_valid, 0);

    wr(9, 16'h1234, 2'b01);
    chk("w9_rf_data", rf.read_data, 16'hA5A5);
    chk("w9_rf_valid", rf.read_valid, 1);
    chk("w9_wf_data", wf.read_data, 16'hA534);
    chk("w9_nc_valid", nc.read_valid, 0);
    chk("w9_nc_hold", nc.read_data, 16'hA5A5);
    rd(9);
    chk("rd9_data", nc.read_data, 16'hA534);
    chk("rd9_valid", nc.read_valid, 1);

    wr(27, 16'h00FF, 2'b11);
    chk("w27a_wf", wf.read_data, 16'h00FF);
    wr(27, 16'hBEEF, 2'b11);
    chk("w27_rf_data", rf.read_data, 16'h00FF);
    chk("w27_rf_valid", rf.read_valid, 1);
    chk("w27_wf_data", wf.read_data, 16'hBEEF);
    chk("w27_wf_valid", wf.read_valid, 1);
    chk("w27_nc_data", nc.read_data, 16'hA534);
    chk("w27_nc_valid", nc.read_valid, 0);
    step();
    chk("w27_rf_pulse", rf.read_valid, 0);
    rd(27);
    chk("rd27_nc", nc.read_data, 16'hBEEF);

    req(1'b1, 21, 16'h1111, 2'b11); step();
    req(1'b1, 22, 16'h2222, 2'b11); step();
    req(1'b1, 23, 16'h3333, 2'b11); step();
    req(1'b1, 21, 16'hFFFF, 2'b00); step();
    req(1'b1, 22, 16'hABCD, 2'b10); step();
    req(1'b0, 21, '0, 2'b00); step();
    chk("b2b21_v", nc.read_valid, 1);
    chk("b2b21_d", nc.read_data, 16'h1111);
    req(1'b0, 22, '0, 2'b00); step();
    chk("b2b22_v", nc.read_valid, 1);
    chk("b2b22_d", nc.read_data, 16'hAB22);
    req(1'b0, 23, '0, 2'b00); step();
    chk("b2b23_v", nc.read_valid, 1);
    chk("b2b23_d", nc.read_data, 16'h3333);
    idle();
    step();
    chk("idle_v", nc.read_valid, 0);
    chk("idle_d", nc.read_data, 16'h3333);
    step();
    step();
    chk("idle_d2", nc.read_data, 16'h3333);

    wr(63, 16'h6363, 2'b11);
    rd(63);
    chk("rd63", nc.read_data, 16'h6363);
    wr(0, 16'h0A0A, 2'b11);
    rd(0);
    chk("rd0", nc.read_data, 16'h0A0A);

    rd(37);
    reset = 1'b1;
    #1;
    chk("inflt_valid", nc.read_valid, 0);
    chk("inflt_data", nc.read_data, 0);
    chk("inflt_rf_data", rf.read_data, 0);
    chk("inflt_ready", nc.req_ready, 0);
    chk("inflt_done", nc.init_done, 0);
    step();
    chk("inflt_valid2", nc.read_valid, 0);
    reset = 1'b0;

    repeat (30) step();
    chk("mid_ready", nc.req_ready, 0);
    reset = 1'b1;
    #1;
    chk("mid_rst_ready", nc.req_ready, 0);
    step();
    reset = 1'b0;
    wait_ready("reinit_cycles");
    rd(27);
    chk("swept27", nc.read_data, 16'hA5A5);
    chk("swept27_v", nc.read_valid, 1);
    rd(63);
    chk("swept63", wf.read_data, 16'hA5A5);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule

// File: doc/param_single_port_ram.md
PARAM_SINGLE_PORT_RAM -- requirements
Module: param_single_port_ram

Interface
REQ-001 Parameter DATA_WIDTH, 8, word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_WIDTH, 6, address width; depth DEPTH = 2**ADDR_WIDTH words.
REQ-003 Parameter WRITE_MODE, MODE_NO_CHANGE, read-port behaviour on write cycles (MODE_READ_FIRST / MODE_WRITE_FIRST / MODE_NO_CHANGE).
REQ-004 Parameter INIT_VALUE, 0, DATA_WIDTH-bit word written to every location by the init sweep.
REQ-005 clock  input  1  sole clock; all state updates on posedge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 req_valid  input  1  request present.
REQ-008 req_ready  output  1  block can accept a request this cycle.
REQ-009 write_enable  input  1  1 = write request, 0 = read request; sampled only on acceptance.
REQ-010 address  input  ADDR_WIDTH  word address.
REQ-011 write_data  input  DATA_WIDTH  write word.
REQ-012 byte_enable  input  DATA_WIDTH/8  per-byte write mask; bit i covers write_data[8i+7:8i].
REQ-013 read_data  output  DATA_WIDTH  registered read word.
REQ-014 read_valid  output  1  one-cycle pulse: read_data updated this cycle.
REQ-015 init_done  output  1  high once the init sweep has completed.

Function
REQ-016 Request accepted exactly when req_valid && req_ready at a posedge.
REQ-017 FSM states: INIT, READY; reset SHALL enter INIT.
REQ-018 INIT: sweep counter from 0 to DEPTH-1, writing INIT_VALUE to one word per cycle; req_ready=0; req_valid ignored.
REQ-019 After writing word DEPTH-1, FSM SHALL move to READY next cycle; init_done and req_ready SHALL go high in that cycle and stay high until reset.
REQ-020 INIT SHALL last exactly DEPTH cycles after reset deassertion.
REQ-021 Accepted write: only lanes with byte_enable[i]=1 updated; other lanes retain prior contents; byte_enable=0 is a legal no-op write.
REQ-022 Accepted read: read_data SHALL present mem[address] and read_valid SHALL pulse high at the following posedge (latency 1).
REQ-023 A write is visible to a read accepted in the next cycle (no hazard bubble).
REQ-024 Write cycle, MODE_READ_FIRST: read_data <= pre-write word, read_valid pulses.
REQ-025 Write cycle, MODE_WRITE_FIRST: read_data <= byte-merged post-write word, read_valid pulses.
REQ-026 Write cycle, MODE_NO_CHANGE: read_data held, read_valid stays 0.
REQ-027 No accepted read, or only NO_CHANGE writes: read_data SHALL hold its last value indefinitely.
REQ-028 Back-to-back requests on consecutive cycles SHALL be accepted at full rate, one per cycle.
REQ-029 Address wrap: no range check needed; all 2**ADDR_WIDTH addresses valid.

Reset
REQ-030 Reset asserted: req_ready=0, read_valid=0, read_data=0, init_done=0, sweep counter=0, state=INIT, all immediately (asynchronously).
REQ-031 Reset mid-INIT or mid-READY SHALL abort, restart the sweep from address 0, and discard any in-flight read (no read_valid).
REQ-032 The storage array is not reset directly; it is cleared only by the sweep.

Structure
REQ-033 Package param_single_port_ram_pkg SHALL hold the MODE_* constants and the FSM state typedef.
REQ-034 Storage SHALL live in one sub-module, sp_ram_array (per-lane write enables, synchronous read), with FSM, handshake and mode muxing in the top.

Verification (DATA_WIDTH=16, ADDR_WIDTH=6, INIT_VALUE=16'hA5A5)
REQ-035 Release reset -> req_ready=0 for exactly 64 cycles, then init_done=1; a read of address 37 returns 16'hA5A5 with read_valid one cycle after acceptance.
REQ-036 Write 16'h1234, byte_enable=2'b01, address 9, then read address 9 next cycle -> read_data=16'hA534.
REQ-037 Per mode: word 27 = 16'h00FF, write 16'hBEEF -> READ_FIRST read_data=16'h00FF with pulse; WRITE_FIRST 16'hBEEF with pulse; NO_CHANGE read_data unchanged, no pulse.
REQ-038 Assert reset at sweep address 30, release -> sweep restarts at 0, 64 more cycles before req_ready=1.
REQ-039 Reads of 21, 22, 23 on consecutive cycles -> three consecutive read_valid pulses with matching data; req_valid held low -> read_data stable.
REQ-040 Assert reset the cycle after a read acceptance -> no read_valid, read_data=0.
